// File: rtl/connect4_pkg.sv
// ============================================================================
// Module  : connect4_pkg
// Purpose : Shared cell codes, line-string geometry and scanner state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package connect4_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam int LINE_BITS        = 398;
  localparam int ROW_REGION_CELLS = 56;
  localparam int PAD_STRIDE       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/window_match.sv
// ============================================================================
// Module  : window_match
// Purpose : Flags four identical player codes in a 4-cell window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module window_match
  import connect4_pkg::*;
(
  input  logic [7:0] cells,
  output logic       match,
  output logic [1:0] code
);

  logic w_same;
  logic w_player;

  assign w_same   = (cells[7:6] == cells[5:4]) &&
                    (cells[5:4] == cells[3:2]) &&
                    (cells[3:2] == cells[1:0]);
  // Empty and invalid codes never count, which also stops runs across pads.
  assign w_player = (cells[7:6] == CELL_P1) || (cells[7:6] == CELL_P2);
  assign match    = w_same && w_player;
  assign code     = match ? cells[7:6] : CELL_EMPTY;

endmodule

`default_nettype wire

// File: rtl/win_scanner.sv
// ============================================================================
// Module  : win_scanner
// Purpose : Snapshots the packed line string and scans one 4-cell window per
//           cycle for the first four-in-a-row. Optional DRAW_DETECT_EN adds
//           the draw output (full row region with no winner).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module win_scanner
  import connect4_pkg::*;
#(
  parameter int CELLS = 199,
  parameter int RUN   = 4,
  parameter int IDX_W = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LINE_BITS-1:0] line_in,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           winner,
  output logic [IDX_W-1:0]     win_index
`ifdef DRAW_DETECT_EN
  ,
  output logic                 draw
`endif
);

  localparam logic [IDX_W-1:0] C_LAST_PTR = IDX_W'(CELLS - RUN);

  scan_state_t          r_state;
  logic [LINE_BITS-1:0] r_snap;
  logic [IDX_W-1:0]     r_ptr;

  logic [1:0]           w_cell [CELLS];
  logic [7:0]           w_window;
  logic                 w_match;
  logic [1:0]           w_code;

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign w_cell[i] = r_snap[LINE_BITS-1-2*i -: 2];
  end

  // r_ptr stops at CELLS-RUN, so ptr+3 always stays inside the cell array.
  assign w_window = {w_cell[r_ptr],
                     w_cell[r_ptr + IDX_W'(1)],
                     w_cell[r_ptr + IDX_W'(2)],
                     w_cell[r_ptr + IDX_W'(3)]};

  window_match u_window_match (
    .cells (w_window),
    .match (w_match),
    .code  (w_code)
  );

`ifdef DRAW_DETECT_EN
  logic [ROW_REGION_CELLS-1:0] w_cell_filled;
  logic                        w_row_full;

  for (genvar j = 0; j < ROW_REGION_CELLS; j++) begin : g_row
    if ((j % PAD_STRIDE) == PAD_STRIDE - 1) begin : g_pad
      assign w_cell_filled[j] = 1'b1;
    end else begin : g_board
      assign w_cell_filled[j] = (w_cell[j] != CELL_EMPTY);
    end
  end

  assign w_row_full = &w_cell_filled;
`endif

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_snap    <= '0;
      r_ptr     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= CELL_EMPTY;
      win_index <= '0;
`ifdef DRAW_DETECT_EN
      draw      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_snap    <= line_in;
            r_ptr     <= '0;
            winner    <= CELL_EMPTY;
            win_index <= '0;
`ifdef DRAW_DETECT_EN
            draw      <= 1'b0;
`endif
            busy      <= 1'b1;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (w_match) begin
            winner    <= w_code;
            win_index <= r_ptr;
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= DONE;
          end else if (r_ptr == C_LAST_PTR) begin
`ifdef DRAW_DETECT_EN
            draw      <= w_row_full;
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_ptr <= r_ptr + IDX_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_win_scanner.sv
// ============================================================================
// Module  : tb_win_scanner
// Purpose : Directed self-checking bench for win_scanner (DRAW_DETECT_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_win_scanner;

  localparam int LIMIT = 260;

  logic         Clk;
  logic         reset;
  logic         start;
  logic [397:0] line_in;
  logic         busy;
  logic         done;
  logic [1:0]   winner;
  logic [7:0]   win_index;
`ifdef DRAW_DETECT_EN
  logic         draw;
`endif

  int n_compared;
  int n_mismatched;

  win_scanner dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .line_in   (line_in),
    .busy      (busy),
    .done      (done),
    .winner    (winner),
    .win_index (win_index)
`ifdef DRAW_DETECT_EN
    ,
    .draw      (draw)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cell(input int i, input logic [1:0] c);
    line_in[397-2*i -: 2] = c;
  endtask

  // Cycle 0 is the cycle whose closing edge samples start; done_cyc is -1 if
  // no done pulse appears within LIMIT cycles.
  task automatic run_scan(input int start2_at, input int reset_at,
                          output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    @(posedge Clk); #1;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 1; n <= LIMIT; n++) begin
      @(negedge Clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = n;
        break;
      end
      if (n == start2_at) begin
        start   = 1'b1;
        line_in = {199{2'b01}};
      end else begin
        start = 1'b0;
      end
      reset = (n == reset_at);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  int dc;
  int bc;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset   = 1'b1;
    start   = 1'b0;
    line_in = '0;
    repeat (3) @(posedge Clk);
    #1 reset = 1'b0;
    @(negedge Clk);
    check_value("rst_busy", 32'(busy), 0);
    check_value("rst_done", 32'(done), 0);
    check_value("rst_winner", 32'(winner), 0);
    check_value("rst_index", 32'(win_index), 0);
`ifdef DRAW_DETECT_EN
    check_value("rst_draw", 32'(draw), 0);
`endif

    // start coincident with reset is dropped
    @(posedge Clk); #1;
    reset = 1'b1; start = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge Clk);
    check_value("rst_start_busy", 32'(busy), 0);

    // all-empty line: full-length scan
    line_in = '0;
    run_scan(-1, -1, dc, bc);
    check_value("empty_done_cyc", 32'(dc), 197);
    check_value("empty_busy_cnt", 32'(bc), 196);
    check_value("empty_winner", 32'(winner), 0);
    check_value("empty_index", 32'(win_index), 0);
    @(negedge Clk);
    check_value("empty_done_pulse", 32'(done), 0);

    // row 0 horizontal P1 run at cells 3..6
    line_in = '0;
    for (int i = 3; i <= 6; i++) set_cell(i, 2'b01);
    run_scan(-1, -1, dc, bc);
    check_value("row0_done_cyc", 32'(dc), 5);
    check_value("row0_winner", 32'(winner), 1);
    check_value("row0_index", 32'(win_index), 3);
`ifdef DRAW_DETECT_EN
    check_value("row0_draw", 32'(draw), 0);
`endif
    repeat (3) @(negedge Clk);
    check_value("row0_hold_winner", 32'(winner), 1);
    check_value("row0_hold_busy", 32'(busy), 0);

    // P2 cells split by the pad at cell 7
    line_in = '0;
    set_cell(5, 2'b10); set_cell(6, 2'b10);
    set_cell(8, 2'b10); set_cell(9, 2'b10);
    run_scan(-1, -1, dc, bc);
    check_value("pad_done_cyc", 32'(dc), 197);
    check_value("pad_winner", 32'(winner), 0);

    // earliest window wins; mid-scan start with new line_in is ignored
    line_in = '0;
    for (int i = 120; i <= 123; i++) set_cell(i, 2'b10);
    for (int i = 150; i <= 153; i++) set_cell(i, 2'b01);
    run_scan(50, -1, dc, bc);
    check_value("first_done_cyc", 32'(dc), 122);
    check_value("first_winner", 32'(winner), 2);
    check_value("first_index", 32'(win_index), 120);

    // last possible window, ptr 195
    line_in = '0;
    for (int i = 195; i <= 198; i++) set_cell(i, 2'b01);
    run_scan(-1, -1, dc, bc);
    check_value("last_done_cyc", 32'(dc), 197);
    check_value("last_winner", 32'(winner), 1);
    check_value("last_index", 32'(win_index), 195);

    // reset at cycle 30 aborts the scan
    line_in = '0;
    for (int i = 100; i <= 103; i++) set_cell(i, 2'b10);
    run_scan(-1, 30, dc, bc);
    check_value("abort_no_done", 32'(dc), 32'hFFFF_FFFF);
    check_value("abort_busy", 32'(busy), 0);
    check_value("abort_winner", 32'(winner), 0);
    check_value("abort_index", 32'(win_index), 0);

    // recovery after abort
    line_in = '0;
    for (int i = 3; i <= 6; i++) set_cell(i, 2'b01);
    run_scan(-1, -1, dc, bc);
    check_value("recover_done_cyc", 32'(dc), 5);
    check_value("recover_winner", 32'(winner), 1);
    check_value("recover_index", 32'(win_index), 3);

`ifdef DRAW_DETECT_EN
    // full row region, pattern 01 01 10 10 01 01 10 per row: no run of four
    line_in = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        set_cell(r*8 + c, ((c/2) % 2 == 0) ? 2'b01 : 2'b10);
    run_scan(-1, -1, dc, bc);
    check_value("draw_done_cyc", 32'(dc), 197);
    check_value("draw_winner", 32'(winner), 0);
    check_value("draw_full", 32'(draw), 1);

    set_cell(10, 2'b00);
    run_scan(-1, -1, dc, bc);
    check_value("draw_hole_winner", 32'(winner), 0);
    check_value("draw_hole", 32'(draw), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/win_scanner.md
Name: win_scanner

Overview:
- Consumes the 398-bit packed line string produced by the board-unpacking stage: rows, columns and diagonals of the 7x7 board, separated by 2'b00 pads.
- On a start pulse it snapshots the string and scans it one 4-cell window per cycle for four consecutive identical player codes.
- Reports the winner, the window position and completion to the game controller.

Parameters:
- CELLS, 199, number of 2-bit cells in the line string (398/2)
- RUN, 4, consecutive cells required for a win
- IDX_W, 8, width of cell index / window pointer

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to scan line_in; honoured only when idle
- line_in  in  398  packed line string; cell i = bits [397-2i : 396-2i] (cell 0 at MSB)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the result is valid
- winner  out  2  00 none, 01 player 1, 10 player 2; held until next accepted start
- win_index  out  IDX_W  start cell of the first winning window; 0 when winner==00
- draw  out  1  present only with DRAW_DETECT_EN (see below)

Behaviour:
- Cell codes: 00 empty, 01 P1, 10 P2, 11 invalid.
  - Empty and invalid never form a win.
  - Pads are 00, so windows spanning two lines cannot match.
- Reset (sync, active-high): state IDLE; busy=0, done=0, winner=00, win_index=0, draw=0; snapshot register cleared. Reset during SCAN aborts the scan with no done pulse.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start=1 -> capture line_in into snapshot, ptr<=0, winner<=00, win_index<=0, draw<=0, go to SCAN.
  - SCAN: evaluate window cells ptr..ptr+3 of the snapshot.
    - Match -> winner<=code, win_index<=ptr, go to DONE.
    - Else if ptr==CELLS-RUN (195) -> DONE with no winner.
    - Else ptr<=ptr+1.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Windows are evaluated in ascending ptr order. The first match wins, so a lower index beats later matches regardless of player.
- Latency (start sampled in cycle 0):
  - Match at ptr=k -> done in cycle k+2.
  - No win -> done in cycle 197.
- start while busy or in DONE is ignored. line_in changes after capture have no effect.
- start in the same cycle as reset: reset wins.
- ptr never exceeds 195 and does not wrap.

Optional Feature:
- Macro: DRAW_DETECT_EN.
- With the macro:
  - draw port exists.
  - At the DONE transition with no winner, draw<=1 if every board cell in the row region is non-empty. Row region = cells 0..55 excluding pad cells j where j%8==7, i.e. 49 cells.
  - draw is evaluated combinationally on the snapshot; no extra latency.
  - draw=0 whenever winner!=00.
- Without the macro: no draw port or logic; behaviour otherwise identical.

Decomposition:
- Package connect4_pkg:
  - cell code constants (CELL_EMPTY, CELL_P1, CELL_P2)
  - LINE_BITS=398, ROW_REGION_CELLS=56, PAD_STRIDE=8
  - scanner state enum {IDLE, SCAN, DONE}
- Sub-module window_match: combinational; inputs 8 bits (4 cells); outputs match and code. Instantiated once in win_scanner.

Test Plan:
- All-zero line_in, start -> done exactly 197 cycles after start, winner=00, win_index=0, busy high cycles 1..196.
- Cells 3..6 = 01 (row_0 horizontal), rest 00 -> done at cycle 5, winner=01, win_index=3.
- Cells 5,6 = 10 in row_0 and cells 8,9 = 10 in row_1 (split by pad cell 7) -> winner=00, no false win across the pad.
- P2 run at cells 120..123 plus P1 run at 150..153 -> winner=10, win_index=120; second start mid-scan at cycle 50 ignored.
- Reset asserted at cycle 30 of a scan -> no done pulse, outputs 00/0; new start then produces a correct result.
- DRAW_DETECT_EN: 49 row cells alternating 01/10 in a pattern with no run of four, other lines arranged to match -> winner=00, draw=1. Same board with one row cell 00 -> draw=0.
